wb_arbiter: RTL

Parametrised writeback stage that merges results from NUM_CH independent execution channels (ALU, load, mul/div, ...) into the single register-file write port and the single fetch-redirect port. Each channel has a valid/ready input with a DEPTH-entry FIFO. A round-robin arbiter retires at most one entry per cycle to registered outputs. Sits between the execute/memory channels and decode (register file) / fetch (PC mux).

---
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs drained round-robin, one entry
// per cycle, onto a registered register-file write port and fetch redirect port.
module wb_arbiter #(
  parameter int NUM_CH = 3,
  parameter int XLEN   = 64,
  parameter int DEPTH  = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  input  logic [NUM_CH-1:0]        IN_V,
  output logic [NUM_CH-1:0]        IN_RDY,
  input  logic [NUM_CH-1:0]        IN_REG_WEN,
  input  logic [NUM_CH*5-1:0]      IN_DR,
  input  logic [NUM_CH*XLEN-1:0]   IN_RES,
  input  logic [NUM_CH-1:0]        IN_PC_MUX,
  input  logic [NUM_CH*XLEN-1:0]   IN_TARGET,
  output logic                     OUT_WB_V,
  output logic [NUM_CH-1:0]        OUT_GNT,
  output logic                     OUT_DE_REG_WEN,
  output logic [4:0]               OUT_DE_DR,
  output logic [XLEN-1:0]          OUT_DE_Data,
  output logic                     OUT_FE_PC_MUX,
  output logic [XLEN-1:0]          OUT_FE_Target_Address
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_CH);

  logic            r_memWen [NUM_CH][DEPTH];
  logic [4:0]      r_memDr  [NUM_CH][DEPTH];
  logic [XLEN-1:0] r_memRes [NUM_CH][DEPTH];
  logic            r_memPcm [NUM_CH][DEPTH];
  logic [XLEN-1:0] r_memTgt [NUM_CH][DEPTH];

  logic [AW-1:0]   r_rdPtr [NUM_CH];
  logic [AW-1:0]   r_wrPtr [NUM_CH];
  logic [CW-1:0]   r_count [NUM_CH];
  logic [PW-1:0]   r_rrPtr;

  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_notEmpty;
  logic [NUM_CH-1:0] w_gnt;
  logic              w_anyGnt;
  logic [PW-1:0]     w_nextPtr;
  logic              w_headWen;
  logic [4:0]        w_headDr;
  logic [XLEN-1:0]   w_headRes;
  logic              w_headPcm;
  logic [XLEN-1:0]   w_headTgt;

  // Ready depends only on the registered count, so a full FIFO never accepts.
  always_comb begin
    IN_RDY     = '0;
    w_notEmpty = '0;
    w_push     = '0;
    w_pop      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      IN_RDY[c]     = (r_count[c] != CW'(DEPTH));
      w_notEmpty[c] = (r_count[c] != '0);
      w_push[c]     = IN_V[c] && IN_RDY[c] && !FLUSH;
      w_pop[c]      = w_gnt[c] && !FLUSH;
    end
  end

  // First non-empty channel found searching from the round-robin pointer.
  always_comb begin
    w_gnt    = '0;
    w_anyGnt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_anyGnt && w_notEmpty[c] && (c == ((int'(r_rrPtr) + i) % NUM_CH))) begin
          w_gnt[c] = 1'b1;
          w_anyGnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_headWen = 1'b0;
    w_headDr  = '0;
    w_headRes = '0;
    w_headPcm = 1'b0;
    w_headTgt = '0;
    w_nextPtr = r_rrPtr;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_gnt[c]) begin
        w_headWen = r_memWen[c][r_rdPtr[c]];
        w_headDr  = r_memDr[c][r_rdPtr[c]];
        w_headRes = r_memRes[c][r_rdPtr[c]];
        w_headPcm = r_memPcm[c][r_rdPtr[c]];
        w_headTgt = r_memTgt[c][r_rdPtr[c]];
        w_nextPtr = (c == NUM_CH - 1) ? '0 : PW'(c + 1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) begin
        r_memWen[c][r_wrPtr[c]] <= IN_REG_WEN[c];
        r_memDr[c][r_wrPtr[c]]  <= IN_DR[5*c +: 5];
        r_memRes[c][r_wrPtr[c]] <= IN_RES[XLEN*c +: XLEN];
        r_memPcm[c][r_wrPtr[c]] <= IN_PC_MUX[c];
        r_memTgt[c][r_wrPtr[c]] <= IN_TARGET[XLEN*c +: XLEN];
      end
    end
  end

  // Flush empties every FIFO but leaves the round-robin pointer where it was.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_rdPtr[c] <= '0;
        r_wrPtr[c] <= '0;
        r_count[c] <= '0;
      end
      r_rrPtr <= '0;
    end else if (FLUSH) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_rdPtr[c] <= '0;
        r_wrPtr[c] <= '0;
        r_count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wrPtr[c] <= r_wrPtr[c] + AW'(1);
        if (w_pop[c])  r_rdPtr[c] <= r_rdPtr[c] + AW'(1);
        if (w_push[c] && !w_pop[c])
          r_count[c] <= r_count[c] + CW'(1);
        else if (!w_push[c] && w_pop[c])
          r_count[c] <= r_count[c] - CW'(1);
      end
      if (w_anyGnt) r_rrPtr <= w_nextPtr;
    end
  end

  // Strobes last one cycle per retirement; payload fields hold between grants.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OUT_WB_V              <= 1'b0;
      OUT_GNT               <= '0;
      OUT_DE_REG_WEN        <= 1'b0;
      OUT_DE_DR             <= '0;
      OUT_DE_Data           <= '0;
      OUT_FE_PC_MUX         <= 1'b0;
      OUT_FE_Target_Address <= '0;
    end else begin
      OUT_WB_V       <= w_anyGnt && !FLUSH;
      OUT_GNT        <= FLUSH ? '0 : w_gnt;
      OUT_DE_REG_WEN <= w_anyGnt && !FLUSH && w_headWen && (w_headDr != 5'd0);
      OUT_FE_PC_MUX  <= w_anyGnt && !FLUSH && w_headPcm;
      if (w_anyGnt && !FLUSH) begin
        OUT_DE_DR             <= w_headDr;
        OUT_DE_Data           <= w_headRes;
        OUT_FE_Target_Address <= w_headTgt;
      end
    end
  end

endmodule
